// File: rtl/pixel_window_packer_if.sv
// -----------------------------------------------------------------------------
// pixel_window_packer_if
//   Bundles the pixel-stream input handshake and the packed-window output
//   handshake of pixel_window_packer.
//
//   in_valid/in_pixel/in_last/in_ready : serial pixel stream (source -> packer)
//   out_valid/pixel_out/short_err/out_ready : packed window (packer -> consumer)
//
//   modport master : the side that sources pixels and consumes windows
//   modport slave  : the packer itself
// -----------------------------------------------------------------------------
interface pixel_window_packer_if #(
    parameter int BIT_WIDTH = 8,
    parameter int NUM_PIX   = 70
);
    logic                           in_valid;
    logic [BIT_WIDTH-1:0]           in_pixel;
    logic                           in_last;
    logic                           in_ready;
    logic                           out_valid;
    logic                           out_ready;
    logic [BIT_WIDTH*NUM_PIX-1:0]   pixel_out;
    logic                           short_err;

    modport master (
        output in_valid, in_pixel, in_last, out_ready,
        input  in_ready, out_valid, pixel_out, short_err
    );

    modport slave (
        input  in_valid, in_pixel, in_last, out_ready,
        output in_ready, out_valid, pixel_out, short_err
    );
endinterface

// File: rtl/pixel_window_packer.sv
// -----------------------------------------------------------------------------
// pixel_window_packer
//   Packs a serial pixel stream (one BIT_WIDTH pixel per accepted handshake)
//   into NUM_PIX-pixel flat windows for the denoise datapath. Two window
//   buffers are used ping-pong: one fills while the other is presented.
//
//   Ports:
//     clk    : system clock, all state on the rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : pixel_window_packer_if.slave
//              in_valid/in_pixel/in_last -> in_ready   (pixel input)
//              out_valid/pixel_out/short_err <- out_ready (window output)
//
//   Window layout: pixel i sits at [BIT_WIDTH*(NUM_PIX-i)-1 -: BIT_WIDTH],
//   so pixel 0 occupies the MSBs.
// -----------------------------------------------------------------------------
module pixel_window_packer #(
    parameter int BIT_WIDTH = 8,
    parameter int NUM_PIX   = 70
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pixel_window_packer_if.slave    bus
);
    localparam int CW = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
    localparam int WW = BIT_WIDTH * NUM_PIX;

    typedef enum logic [1:0] {
        BUF_EMPTY   = 2'd0,
        BUF_FILLING = 2'd1,
        BUF_FULL    = 2'd2
    } buf_state_e;

    buf_state_e             state_q [2];
    buf_state_e             state_d [2];
    logic [BIT_WIDTH-1:0]   lane_q  [2][NUM_PIX];
    logic [BIT_WIDTH-1:0]   lane_d  [2][NUM_PIX];
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          pix_cnt_q, pix_cnt_d;
    logic                   short_err_q, short_err_d;
    logic [WW-1:0]          pixel_out_q, pixel_out_d;
    logic [WW-1:0]          next_window;

    logic                   in_ready;
    logic                   out_valid;
    logic                   accept;
    logic                   out_hs;
    logic                   at_end;
    logic                   close;

    // ---------------------------------------------------------------------
    // Output decode: both handshake outputs come from registered state only.
    // in_ready is also held low while reset is asserted.
    // ---------------------------------------------------------------------
    always_comb begin
        in_ready  = rst_n && (state_q[wr_ptr_q] != BUF_FULL);
        out_valid = (state_q[rd_ptr_q] == BUF_FULL);
    end

    assign accept = bus.in_valid & in_ready;
    assign out_hs = out_valid & bus.out_ready;
    assign at_end = (pix_cnt_q == CW'(NUM_PIX - 1));
    assign close  = accept & (at_end | bus.in_last);

    // ---------------------------------------------------------------------
    // Per-buffer state: EMPTY -> FILLING -> FULL -> EMPTY
    // A single-pixel window goes EMPTY -> FULL directly.
    // ---------------------------------------------------------------------
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            state_d[b] = state_q[b];
            case (state_q[b])
                BUF_EMPTY: begin
                    if (accept && (wr_ptr_q == 1'(b)))
                        state_d[b] = close ? BUF_FULL : BUF_FILLING;
                end
                BUF_FILLING: begin
                    if (close && (wr_ptr_q == 1'(b)))
                        state_d[b] = BUF_FULL;
                end
                BUF_FULL: begin
                    if (out_hs && (rd_ptr_q == 1'(b)))
                        state_d[b] = BUF_EMPTY;
                end
                default: state_d[b] = BUF_EMPTY;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Lane write. The first pixel of a window clears every other lane of the
    // target buffer, so a short window never exposes stale pixels.
    // ---------------------------------------------------------------------
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            for (int l = 0; l < NUM_PIX; l++) begin
                lane_d[b][l] = lane_q[b][l];
                if (accept && (wr_ptr_q == 1'(b))) begin
                    if (pix_cnt_q == CW'(l))
                        lane_d[b][l] = bus.in_pixel;
                    else if (pix_cnt_q == '0)
                        lane_d[b][l] = '0;
                end
            end
        end
    end

    always_comb begin
        wr_ptr_d    = close  ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d    = out_hs ? ~rd_ptr_q : rd_ptr_q;
        short_err_d = close & ~at_end;
        if (close)
            pix_cnt_d = '0;
        else if (accept)
            pix_cnt_d = pix_cnt_q + CW'(1);
        else
            pix_cnt_d = pix_cnt_q;
    end

    // ---------------------------------------------------------------------
    // pixel_out is its own register: it loads the buffer that will be
    // presented next cycle (including a pixel written on this very edge) and
    // otherwise holds, so it keeps the last window once out_valid drops even
    // if that buffer starts refilling.
    // ---------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_PIX; gi++) begin : g_flat
        assign next_window[BIT_WIDTH*(NUM_PIX-gi)-1 -: BIT_WIDTH] = lane_d[rd_ptr_d][gi];
    end

    assign pixel_out_d = (state_d[rd_ptr_d] == BUF_FULL) ? next_window : pixel_out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= BUF_EMPTY;
                for (int l = 0; l < NUM_PIX; l++)
                    lane_q[b][l] <= '0;
            end
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            pix_cnt_q   <= '0;
            short_err_q <= 1'b0;
            pixel_out_q <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= state_d[b];
                for (int l = 0; l < NUM_PIX; l++)
                    lane_q[b][l] <= lane_d[b][l];
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pix_cnt_q   <= pix_cnt_d;
            short_err_q <= short_err_d;
            pixel_out_q <= pixel_out_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.pixel_out = pixel_out_q;
    assign bus.short_err = short_err_q;

endmodule

// File: tb/tb_pixel_window_packer.sv
// -----------------------------------------------------------------------------
// tb_pixel_window_packer
//   Directed scenarios plus a randomized stream. A reference model turns the
//   accepted pixel stream into expected windows (queue of zero-padded windows)
//   and a monitor compares every presented window, the short_err pulse, the
//   one-cycle output latency and the hold behaviour of pixel_out.
// -----------------------------------------------------------------------------
module tb_pixel_window_packer;
    localparam int BW = 8;
    localparam int NP = 70;
    localparam int WW = BW * NP;

    typedef logic [WW-1:0] win_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pixel_window_packer_if #(.BIT_WIDTH(BW), .NUM_PIX(NP)) bus ();

    pixel_window_packer #(.BIT_WIDTH(BW), .NUM_PIX(NP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input win_t act, input win_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ------------------------------------------------------------------
    // Reference model: windows are formed from accepted pixels; a window is
    // NP pixels or ends early at in_last, missing pixels read as zero.
    // ------------------------------------------------------------------
    logic [BW-1:0] cur_pix[$];
    win_t          exp_q[$];
    bit            short_exp;
    bit            valid_exp;
    win_t          last_out;
    int            n_windows_out;

    function automatic win_t pack_window(input logic [BW-1:0] px[$]);
        win_t w = '0;
        for (int i = 0; i < px.size(); i++)
            w[BW*(NP-i)-1 -: BW] = px[i];
        return w;
    endfunction

    // Monitor: inputs change #1 after posedge, so the negedge sees exactly
    // what the next posedge will act on.
    always @(negedge clk) begin
        if (!rst_n) begin
            cur_pix.delete();
            exp_q.delete();
            short_exp = 1'b0;
            valid_exp = 1'b0;
            last_out  = '0;
        end else begin
            chk("short_err", win_t'(bus.short_err), win_t'(short_exp));
            short_exp = 1'b0;
            if (valid_exp) chk("out_latency", win_t'(bus.out_valid), win_t'(1));
            valid_exp = 1'b0;

            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_window: got %0h expected no window", bus.pixel_out);
                end else begin
                    chk("window", bus.pixel_out, exp_q[0]);
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        n_windows_out++;
                    end
                end
                last_out = bus.pixel_out;
            end else begin
                chk("idle_hold", bus.pixel_out, last_out);
            end

            if (bus.in_valid && bus.in_ready) begin
                cur_pix.push_back(bus.in_pixel);
                if (cur_pix.size() == NP || bus.in_last) begin
                    valid_exp = (exp_q.size() == 0);
                    short_exp = (cur_pix.size() < NP);
                    exp_q.push_back(pack_window(cur_pix));
                    cur_pix.delete();
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    task automatic send(input logic [BW-1:0] p, input bit last);
        bit got;
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_pixel = p;
        bus.in_last  = last;
        forever begin
            @(negedge clk);
            got = bus.in_ready;
            @(posedge clk);
            #1;
            if (got) break;
            if (++t > 2000) begin
                n_checks++;
                $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", t);
                break;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'($urandom);
        bus.in_pixel = BW'($urandom);
    endtask

    task automatic drain();
        for (int t = 0; t < 1000 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        chk("drain_empty", win_t'(exp_q.size()), win_t'(0));
    endtask

    bit rnd_run;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_pixel  = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        n_windows_out = 0;
        rnd_run       = 1'b0;

        // Reset state
        #12;
        chk("rst_in_ready",  win_t'(bus.in_ready),  win_t'(0));
        chk("rst_out_valid", win_t'(bus.out_valid), win_t'(0));
        chk("rst_pixel_out", bus.pixel_out,         win_t'(0));
        chk("rst_short_err", win_t'(bus.short_err), win_t'(0));
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: one back-to-back window 0x00..0x45
        bus.out_ready = 1'b1;
        for (int i = 0; i < NP; i++) send(BW'(i), 1'b0);
        drain();

        // 2: three windows with the output stalled
        bus.out_ready = 1'b0;
        for (int i = 0; i < NP; i++) send(BW'(8'h10 + i), 1'b0);
        for (int i = 0; i < NP; i++) send(BW'(8'h20 + i), 1'b0);
        @(negedge clk);
        chk("both_full_in_ready", win_t'(bus.in_ready), win_t'(0));
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < NP; i++) send(BW'(8'h30 + i), 1'b0);
            end
            begin
                repeat (4) begin
                    @(negedge clk);
                    chk("stall_in_ready", win_t'(bus.in_ready), win_t'(0));
                end
                @(posedge clk); #1 bus.out_ready = 1'b1;
                @(posedge clk); #1 bus.out_ready = 1'b0;
                @(negedge clk);
                chk("release_in_ready", win_t'(bus.in_ready), win_t'(1));
            end
        join
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
        drain();

        // 3: short window A1..A5
        for (int i = 0; i < 5; i++) send(BW'(8'hA1 + i), i == 4);
        drain();

        // 4: full 0xFF window, then short 0x11,0x22
        for (int i = 0; i < NP; i++) send(8'hFF, 1'b0);
        send(8'h11, 1'b0);
        send(8'h22, 1'b1);
        drain();

        // 5: ten consecutive windows, closing write meets output handshake
        for (int w = 0; w < 10; w++)
            for (int i = 0; i < NP; i++) send(BW'(w * 16 + i), 1'b0);
        drain();

        // 6: reset mid-window while the other buffer is full
        bus.out_ready = 1'b0;
        for (int i = 0; i < NP; i++) send(BW'(8'h60 + i), 1'b0);
        for (int i = 0; i < 30; i++) send(BW'(8'h90 + i), 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", win_t'(bus.out_valid), win_t'(0));
        chk("midrst_pixel_out", bus.pixel_out,         win_t'(0));
        chk("midrst_in_ready",  win_t'(bus.in_ready),  win_t'(0));
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < NP; i++) send(BW'(8'h50 + i), 1'b0);
        drain();

        // 7: randomized stream with random gaps, in_last and back-pressure
        rnd_run = 1'b1;
        fork
            begin
                while (rnd_run) begin
                    @(posedge clk); #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int i = 0; i < 500; i++) begin
                    if ($urandom_range(0, 4) == 0) begin
                        @(posedge clk); #1;
                    end
                    send(BW'($urandom), (i == 499) || ($urandom_range(0, 29) == 0));
                end
                rnd_run = 1'b0;
            end
        join
        @(posedge clk); #1 bus.out_ready = 1'b1;
        drain();
        chk("model_partial_empty", win_t'(cur_pix.size()), win_t'(0));

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pixel_window_packer.md
Name: pixel_window_packer

Overview:
- Input-side feeder for the denoise datapath: accepts a serial pixel stream (one BIT_WIDTH pixel per handshake) and packs NUM_PIX pixels into one flat window vector matching the denoise `pix_in` layout.
- Ping-pong double buffer: one window is filled while the previous one is held for the downstream consumer.
- Sits between the pixel source (memory reader/DMA) and the denoise window input.

Parameters:
BIT_WIDTH, 8, bits per pixel
NUM_PIX, 70, pixels per packed window

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream pixel valid
in_pixel  input  BIT_WIDTH  upstream pixel
in_last  input  1  marks final pixel of a (possibly short) window; sampled only on accept
in_ready  output  1  packer can accept a pixel this cycle
out_valid  output  1  a complete window is presented on pixel_out
out_ready  input  1  downstream consumes window
pixel_out  output  BIT_WIDTH*NUM_PIX  packed window; pixel i at [BIT_WIDTH*(NUM_PIX-i)-1 -: BIT_WIDTH] (pixel 0 at MSBs, e.g. [559:552])
short_err  output  1  one-cycle pulse: window closed by in_last before NUM_PIX pixels

Behaviour:
- Reset (async, rst_n=0): both buffers zero and EMPTY, wr_ptr=rd_ptr=0, pix_cnt=0, in_ready=0 during reset, out_valid=0, pixel_out=0, short_err=0. Reset mid-window discards all partial and full data.
- Per-buffer state: EMPTY -> FILLING (first pixel accepted) -> FULL (last pixel accepted) -> EMPTY (output handshake).
- Input accept = in_valid & in_ready. in_ready = buffer[wr_ptr] not FULL; registered-state only, with no combinational path from out_ready.
- On accept: write in_pixel to lane pix_cnt of buffer[wr_ptr]. When pix_cnt==0, all other lanes of that buffer clear to 0 on the same edge.
- pix_cnt increments 0..NUM_PIX-1. The window closes when pix_cnt==NUM_PIX-1 or in_last=1 on the accept.
- On close:
  - buffer[wr_ptr] becomes FULL; pix_cnt wraps to 0; wr_ptr toggles.
  - If closed by in_last with pix_cnt<NUM_PIX-1: unwritten lanes stay 0 and short_err pulses high the next cycle.
  - in_last at pix_cnt==NUM_PIX-1 is a normal close with no error.
- Output: out_valid = buffer[rd_ptr] FULL (registered state). pixel_out = buffer[rd_ptr] contents, held stable while out_valid=1 and out_ready=0.
- Handshake out_valid & out_ready: buffer[rd_ptr] becomes EMPTY and rd_ptr toggles.
  - If the other buffer is FULL, out_valid stays 1 with the new window on the next cycle.
  - Otherwise out_valid drops.
  - pixel_out holds its last value when out_valid=0.
- Latency: the window closing on edge k gives out_valid=1 in the cycle after edge k, when the output side is idle. Throughput is 1 pixel/cycle sustained when out_ready keeps pace.
- Simultaneous events:
  - Closing write into one buffer plus output handshake of the other on the same edge: both take effect, with no pixel lost or duplicated.
  - Both buffers FULL: in_ready=0. It returns to 1 the cycle after the output handshake frees buffer[wr_ptr].
- in_pixel, in_last are don't-care when in_valid=0 or in_ready=0. Source must hold data while stalled.

Test Plan:
- Reset then stream pixels 0x00..0x45 (70) back-to-back, out_ready=1 -> out_valid=1 one cycle after the 70th accept; pixel_out[559:552]=0x00, [7:0]=0x45; short_err never pulses.
- out_ready=0, stream 3 full windows (values 0x10+n, 0x20+n, 0x30+n) -> in_ready drops after 140 accepts; pixel_out holds window 1; releasing out_ready for one cycle re-raises in_ready the next cycle; windows emerge in order 1,2,3.
- Send 5 pixels 0xA1..0xA5 with in_last on the 5th -> short_err one-cycle pulse; pixel_out lanes 0..4=A1..A5, lanes 5..69=0x00.
- Full window of 0xFF followed by a short window of 2 pixels 0x11,0x22 -> second window lanes 2..69 are 0x00 (no stale 0xFF).
- Closing write to buffer B on the same edge as output handshake of buffer A -> next cycle out_valid=1 with buffer B data; no gap or duplicate over 10 consecutive windows with out_ready=1.
- Assert rst_n=0 after 30 pixels of a window while the other buffer is FULL -> out_valid=0, pixel_out=0 immediately; next full window after release starts at lane 0.
